// File: rtl/result_uart_reporter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : result_uart_reporter_pkg                                      |
// | Brief    : Shared host-link constants, FSM states and frame byte mux.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package result_uart_reporter_pkg;

    localparam int          c_FRAME_BYTES   = 10;
    localparam int          c_BITS_PER_BYTE = 10;
    localparam logic [7:0]  c_HEADER        = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Snapshot layout is {r4, r3, r2, r1}; frame index 1..8 walks the words high byte first.
    function automatic logic [7:0] frame_byte(input logic [47:0] snap, input logic [3:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            4'd1:    b = {4'h0, snap[11:8]};
            4'd2:    b = snap[7:0];
            4'd3:    b = {4'h0, snap[23:20]};
            4'd4:    b = snap[19:12];
            4'd5:    b = {4'h0, snap[35:32]};
            4'd6:    b = snap[31:24];
            4'd7:    b = {4'h0, snap[47:44]};
            4'd8:    b = snap[43:36];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/result_uart_reporter_uart_tx_byte.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_tx_byte                                                  |
// | Brief    : 8N1 byte serialiser; ready also covers the final stop cycle   |
// |            so a new byte can follow with no idle gap.                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_tx_byte
    import result_uart_reporter_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int                  c_BAUD_W   = $clog2(CLKS_PER_BIT);
    localparam logic [c_BAUD_W-1:0] c_BAUD_MAX = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]          c_LAST_BIT = 4'(c_BITS_PER_BYTE - 1);

    logic                r_busy;
    logic                r_tx;
    logic [c_BAUD_W-1:0] r_baud;
    logic [3:0]          r_bit_idx;
    logic [8:0]          r_shift;
    logic                w_last_cycle;

    assign w_last_cycle = r_busy && (r_bit_idx == c_LAST_BIT) && (r_baud == c_BAUD_MAX);
    assign ready        = !r_busy || w_last_cycle;
    assign tx           = r_tx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy    <= 1'b0;
            r_tx      <= 1'b1;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '1;
        end else if (start && ready) begin
            // Start bit goes out directly; shift holds data then the stop bit.
            r_busy    <= 1'b1;
            r_tx      <= 1'b0;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= {1'b1, data};
        end else if (r_busy) begin
            if (r_baud == c_BAUD_MAX) begin
                r_baud <= '0;
                if (r_bit_idx == c_LAST_BIT) begin
                    r_busy    <= 1'b0;
                    r_tx      <= 1'b1;
                    r_bit_idx <= '0;
                end else begin
                    r_bit_idx <= r_bit_idx + 4'd1;
                    r_tx      <= r_shift[0];
                    r_shift   <= {1'b1, r_shift[8:1]};
                end
            end else begin
                r_baud <= r_baud + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/result_uart_reporter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : result_uart_reporter                                          |
// | Brief    : On end_process rising, snapshots r1..r4 and sends a framed    |
// |            UART packet: A5, 8 data bytes, XOR checksum.                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module result_uart_reporter
    import result_uart_reporter_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         WORD_W       = 12,
    parameter logic [7:0] HEADER       = c_HEADER
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              end_process,
    input  logic [WORD_W-1:0] r1,
    input  logic [WORD_W-1:0] r2,
    input  logic [WORD_W-1:0] r3,
    input  logic [WORD_W-1:0] r4,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam logic [3:0] c_CSUM_IDX = 4'(c_FRAME_BYTES - 1);
    localparam logic [3:0] c_END_IDX  = 4'(c_FRAME_BYTES);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_ep_q;
    logic [4*WORD_W-1:0] r_snap;
    logic [3:0]        r_idx;
    logic [7:0]        r_csum;
    logic [7:0]        r_pend;
    logic              w_start;
    logic              w_tx_start;
    logic [7:0]        w_tx_data;
    logic              w_tx_ready;
    logic [7:0]        w_byte;

    assign busy    = (r_state != ST_IDLE);
    assign done    = (r_state == ST_DONE);
    assign w_start = end_process && !r_ep_q && !busy;
    assign w_byte  = frame_byte(r_snap, r_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The header is handed to the serialiser on the detect edge itself so tx
    // falls together with busy; the LOAD/SEND loop then covers bytes 1..9.
    always_comb begin
        w_state_nxt = r_state;
        w_tx_start  = 1'b0;
        w_tx_data   = r_pend;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_tx_start  = 1'b1;
                    w_tx_data   = HEADER;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: w_state_nxt = ST_SEND;
            ST_SEND: begin
                if (w_tx_ready) begin
                    if (r_idx == c_END_IDX) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_tx_start  = 1'b1;
                        w_state_nxt = (r_idx == c_CSUM_IDX) ? ST_SEND : ST_LOAD;
                    end
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ep_q <= 1'b0;
            r_snap <= '0;
            r_idx  <= '0;
            r_csum <= '0;
            r_pend <= '0;
        end else begin
            r_ep_q <= end_process;
            case (r_state)
                ST_IDLE: begin
                    r_idx  <= '0;
                    r_csum <= '0;
                    if (w_start) begin
                        r_snap <= {r4, r3, r2, r1};
                        r_idx  <= 4'd1;
                    end
                end
                ST_LOAD: begin
                    if (r_idx == c_CSUM_IDX) begin
                        r_pend <= r_csum;
                    end else begin
                        r_pend <= w_byte;
                        r_csum <= r_csum ^ w_byte;
                    end
                end
                ST_SEND: begin
                    if (w_tx_start) begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk   (clk),
        .rst   (rst),
        .start (w_tx_start),
        .data  (w_tx_data),
        .tx    (tx),
        .ready (w_tx_ready)
    );

endmodule
`default_nettype wire

// File: tb/tb_result_uart_reporter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_result_uart_reporter                                       |
// | Brief    : Directed bench; mid-bit UART monitor decodes each frame.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_result_uart_reporter;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        end_process = 1'b0;
    logic [11:0] r1 = '0, r2 = '0, r3 = '0, r4 = '0;
    logic        tx, busy, done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;

    logic [7:0] exp1 [10];
    logic [7:0] exp2 [10];

    result_uart_reporter #(
        .CLKS_PER_BIT (CPB),
        .WORD_W       (12),
        .HEADER       (8'hA5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .end_process (end_process),
        .r1          (r1),
        .r2          (r2),
        .r3          (r3),
        .r4          (r4),
        .tx          (tx),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on a negedge; returns 1.5 cycles into the stop bit.
    task automatic recv_byte(output logic [7:0] b, output int start_cyc);
        int n;
        n = 0;
        b = 8'h00;
        while (tx !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rx_start_found", 32'(n < 200), 32'd1);
        start_cyc = cyc;
        @(negedge clk);
        check("start_bit", 32'(tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        check("stop_bit", 32'(tx), 32'd1);
    endtask

    // act: 0 none, 1 corrupt r1/r4 before byte at_byte, 2 glitch end_process there.
    task automatic recv_frame(input logic [7:0] exp [10], input int at_byte, input int act);
        logic [7:0] b;
        int sc, prev;
        prev = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == at_byte && act == 1) begin
                r1 = 12'h000;
                r4 = 12'h000;
            end
            if (i == at_byte && act == 2) begin
                end_process = 1'b0;
                @(negedge clk);
                end_process = 1'b1;
            end
            recv_byte(b, sc);
            check($sformatf("byte%0d", i), 32'(b), 32'(exp[i]));
            if (i > 0) check($sformatf("gap%0d", i), sc - prev, CPB * 10);
            prev = sc;
        end
    endtask

    // Entered 1.5 cycles into the checksum stop bit.
    task automatic check_done_pulse();
        repeat (3) @(negedge clk);
        check("done_high", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd1);
        @(negedge clk);
        check("done_low", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
        check("tx_idle_after", 32'(tx), 32'd1);
    endtask

    task automatic set_words(input logic [11:0] a, b, c, d);
        r1 = a; r2 = b; r3 = c; r4 = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n_raise, dc0, bad, n;
        logic [7:0] b;
        int sc;

        exp1 = '{8'hA5, 8'h01, 8'h23, 8'h04, 8'h56, 8'h07, 8'h89, 8'h0A, 8'hBC, 8'h48};
        exp2 = '{8'hA5, 8'h0F, 8'hFF, 8'h0F, 8'hFF, 8'h0F, 8'hFF, 8'h0F, 8'hFF, 8'h00};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 1: basic frame, latency and done timing
        set_words(12'h123, 12'h456, 12'h789, 12'hABC);
        end_process = 1'b1;
        n_raise = cyc;
        check("t1_tx_before", 32'(tx), 32'd1);
        @(negedge clk);
        check("t1_tx_latency", 32'(tx), 32'd0);
        check("t1_busy_latency", 32'(busy), 32'd1);
        recv_frame(exp1, -1, 0);
        check_done_pulse();
        check("t1_done_cycle", done_cyc - n_raise, 401);
        end_process = 1'b0;
        repeat (2) @(negedge clk);

        // 2: all ones
        set_words(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
        end_process = 1'b1;
        recv_frame(exp2, -1, 0);
        check_done_pulse();
        end_process = 1'b0;
        repeat (2) @(negedge clk);

        // 3: inputs change mid-frame
        set_words(12'h123, 12'h456, 12'h789, 12'hABC);
        end_process = 1'b1;
        recv_frame(exp1, 3, 1);
        check_done_pulse();
        end_process = 1'b0;
        repeat (2) @(negedge clk);

        // 4: glitch while busy, hold high, then re-raise
        set_words(12'h123, 12'h456, 12'h789, 12'hABC);
        dc0 = done_cnt;
        end_process = 1'b1;
        recv_frame(exp1, 3, 2);
        check_done_pulse();
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        check("t4_no_retrigger", bad, 0);
        check("t4_single_done", done_cnt - dc0, 1);
        end_process = 1'b0;
        @(negedge clk);
        end_process = 1'b1;
        recv_frame(exp1, -1, 0);
        check_done_pulse();
        check("t4_second_done", done_cnt - dc0, 2);
        end_process = 1'b0;
        repeat (2) @(negedge clk);

        // 5: async reset mid-frame, release with end_process high
        end_process = 1'b1;
        for (int i = 0; i < 4; i++) begin
            recv_byte(b, sc);
            check($sformatf("t5_pre_byte%0d", i), 32'(b), 32'(exp1[i]));
        end
        n = 0;
        while (tx !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t5_byte4_found", 32'(n < 200), 32'd1);
        repeat (24) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("t5_rst_tx", 32'(tx), 32'd1);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        recv_frame(exp1, -1, 0);
        check_done_pulse();
        end_process = 1'b0;
        repeat (2) @(negedge clk);

        // 6: quiet after reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dc0 = done_cnt;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        check("t6_idle", bad, 0);
        check("t6_no_done", done_cnt - dc0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
